// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Receive half of the UART link. Deserialises an asynchronous frame from the
//   pin rxd_i into a byte and hands it to the core with a single-cycle pulse.
//   Default frame is 8N1: start bit, 8 data bits LSB first, stop bit.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined     -> frame is 8E1. A parity bit follows the data bits. The
//                    combined parity of the data and parity bits must be even.
//     not defined -> frame is 8N1 and parity_err_o is tied low.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit. This matches the transmitter baud tick.
//   SYNC_STAGES   number of flops in the rxd synchroniser. Must be >= 2.
//
// Ports
//   clk           system clock. All logic runs on posedge.
//   reset         synchronous, active-high.
//   rxd_i         serial line. Idles high and is asynchronous to clk.
//   rx_data_o     last good byte. Held until the next good frame completes.
//   rx_valid_o    one-cycle pulse: rx_data_o was updated by a good frame.
//   frame_err_o   one-cycle pulse: the stop bit was sampled low.
//   parity_err_o  one-cycle pulse alongside rx_valid_o on a parity mismatch.
//   rx_busy_o     high from start-bit detect until the receiver returns to idle.
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 501,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       rx_busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    // The last count of a full bit period.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // The offset from the start-bit edge to the middle of the start bit.
    // Every later sample then lands one full bit period further on.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_BREAK  = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   rxs;

    state_t                 state_q;
    logic [CNT_W-1:0]       clk_cnt_q;
    logic [2:0]             bit_idx_q;
    logic [7:0]             shift_q;
    logic [7:0]             data_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   perr_q;
    logic                   busy_q;
`ifdef UART_RX_PARITY_EN
    logic                   par_q;
`endif

    // New samples enter at bit 0. The oldest, settled sample drives the FSM.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], rxd_i};
    assign rxs    = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            // The synchroniser resets to the idle line level. This prevents a
            // false start bit straight out of reset.
            sync_q    <= '1;
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            // The status outputs are pulses. They default low every cycle.
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        state_q   <= S_START;
                        clk_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end

                S_START: begin
                    if (clk_cnt_q == CNT_HALF) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        if (!rxs) begin
                            state_q <= S_DATA;
                        end else begin
                            // The line went high again before mid start bit.
                            // Treat it as a glitch and drop it silently.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (clk_cnt_q == CNT_LAST) begin
                        clk_cnt_q          <= '0;
                        shift_q[bit_idx_q] <= rxs;
                        bit_idx_q          <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (clk_cnt_q == CNT_LAST) begin
                        clk_cnt_q <= '0;
                        par_q     <= rxs;
                        state_q   <= S_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (clk_cnt_q == CNT_LAST) begin
                        clk_cnt_q <= '0;
                        if (rxs) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            // For even parity, the XOR of the data and
                            // parity bits must be zero.
                            perr_q  <= ^{shift_q, par_q};
`endif
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            // On a bad stop bit, the byte is discarded and
                            // any parity result is suppressed.
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end

                S_BREAK: begin
                    // Stay here while the line is held low. A new start bit
                    // needs a fresh falling edge.
                    if (rxs) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = ferr_q;
    assign rx_busy_o   = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule
